// File: rtl/ask_pkg.sv
// ask_pkg: shared definitions for the ASK (on-off-keying) demodulator and
// the matching modulator bench.
//   - ask_state_t    : demodulator alignment state (HUNT / TRACK)
//   - CARRIER_DIV    : carrier period in clocks (high for half, low for half)
//   - DEF_*          : default symbol length, slicer threshold, loss run
//                      length and counter width
//   - ideal_one_count: high samples an unmodulated-noise-free 1-symbol yields
package ask_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } ask_state_t;

  localparam int CARRIER_DIV   = 4;

  localparam int DEF_SYM_LEN   = 16;
  localparam int DEF_THRESH    = 4;
  localparam int DEF_LOSS_SYMS = 8;
  localparam int DEF_CNT_W     = 5;

  // A gated divide-by-CARRIER_DIV carrier is high for half of each period,
  // so a full 1-symbol contributes half of its samples.
  function automatic int ideal_one_count(input int sym_len);
    return (sym_len / CARRIER_DIV) * (CARRIER_DIV / 2);
  endfunction

endpackage

// File: rtl/ask_demod_if.sv
// ask_demod_if: signal bundle between an ASK waveform source and the
// demodulator.
//   y          : 1-bit ASK waveform, synchronous to the shared clock
//   x_out      : recovered baseband bit (held between decisions)
//   bit_valid  : one-cycle strobe, x_out updated this cycle
//   locked     : symbol window aligned
//   stuck_err  : one-cycle strobe with bit_valid, window was all-high
// Modports: master = waveform source / observer, slave = demodulator.
interface ask_demod_if;

  logic y;
  logic x_out;
  logic bit_valid;
  logic locked;
  logic stuck_err;

  modport master (
    output y,
    input  x_out,
    input  bit_valid,
    input  locked,
    input  stuck_err
  );

  modport slave (
    input  y,
    output x_out,
    output bit_valid,
    output locked,
    output stuck_err
  );

endinterface

// File: rtl/ask_win_acc.sv
// ask_win_acc: symbol-window phase counter and high-sample accumulator.
//   clk, rst     : clock, synchronous active-high reset
//   start        : current sample is window sample 0 (aligning edge)
//   sample       : current ASK sample
//   enable       : window is running (tracking); accumulate this sample
//   window_done  : this sample is the last one of the window
//   count        : high samples in the window including this sample; it is
//                  the final window total when window_done is high
module ask_win_acc #(
  parameter int SYM_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample,
  input  logic             enable,
  output logic             window_done,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] acc_q;

  assign window_done = enable && (phase_q == CNT_W'(SYM_LEN - 1));

  // Running total including the sample on the wire now, so the slicer sees
  // the complete window in the same cycle as its last sample.
  assign count = acc_q + {{(CNT_W-1){1'b0}}, sample};

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      acc_q   <= '0;
    end else if (start) begin
      // The aligning edge is itself a high sample at phase 0.
      phase_q <= CNT_W'(1);
      acc_q   <= CNT_W'(1);
    end else if (enable) begin
      if (window_done) begin
        phase_q <= '0;
        acc_q   <= '0;
      end else begin
        phase_q <= phase_q + 1'b1;
        acc_q   <= count;
      end
    end
  end

endmodule

// File: rtl/ask_demod.sv
// ask_demod: on-off-keying demodulator for the divide-by-4 gated carrier.
// Hunts for the first carrier rising edge, aligns a SYM_LEN-clock window to
// it, counts high samples per window and slices the count against THRESH.
// LOSS_SYMS consecutive decoded zeros drop back to hunting (0 disables).
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   bus.y      : ASK waveform input
//   bus.x_out  : recovered bit, held until the next decision
//   bus.bit_valid : one-cycle decision strobe
//   bus.locked : high while tracking an aligned window
//   bus.stuck_err : one-cycle strobe with bit_valid for an all-high window
// Legal parameters: SYM_LEN multiple of 4 and >= 4, 1 <= THRESH <= SYM_LEN,
// 2**CNT_W > SYM_LEN.
module ask_demod
  import ask_pkg::*;
#(
  parameter int SYM_LEN   = DEF_SYM_LEN,
  parameter int THRESH    = DEF_THRESH,
  parameter int LOSS_SYMS = DEF_LOSS_SYMS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  ask_demod_if.slave  bus
);

  localparam int ZR_W = (LOSS_SYMS > 0) ? $clog2(LOSS_SYMS + 1) : 1;

  ask_state_t       state_q;
  ask_state_t       state_d;
  logic             y_q;
  logic [ZR_W-1:0]  zero_run_q;
  logic [ZR_W-1:0]  zero_run_inc;
  logic             x_q;
  logic             bit_valid_q;
  logic             stuck_q;

  logic             rise;
  logic             start;
  logic             enable;
  logic             window_done;
  logic [CNT_W-1:0] count;
  logic             dec_one;
  logic             lose;

  ask_win_acc #(
    .SYM_LEN (SYM_LEN),
    .CNT_W   (CNT_W)
  ) u_win (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sample      (bus.y),
    .enable      (enable),
    .window_done (window_done),
    .count       (count)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    rise         = bus.y && !y_q;
    dec_one      = (count >= CNT_W'(THRESH));
    zero_run_inc = zero_run_q + 1'b1;
    lose         = window_done && !dec_one && (LOSS_SYMS > 0) &&
                   (zero_run_inc == ZR_W'(LOSS_SYMS));
    start        = (state_q == HUNT) && rise;
    enable       = (state_q == TRACK);

    case (state_q)
      HUNT:    if (rise) state_d = TRACK;
      TRACK:   if (lose) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= 1'b0;
      zero_run_q  <= '0;
      x_q         <= 1'b0;
      bit_valid_q <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      y_q         <= bus.y;
      bit_valid_q <= window_done;
      stuck_q     <= window_done && (count == CNT_W'(SYM_LEN));
      if (window_done) begin
        x_q <= dec_one;
        // The run restarts both on a decoded 1 and on the loss decision
        // itself, so a relock begins with a clean count.
        if (dec_one || lose) zero_run_q <= '0;
        else                 zero_run_q <= zero_run_inc;
      end
    end
  end

  assign bus.x_out     = x_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.stuck_err = stuck_q;
  assign bus.locked    = (state_q == TRACK);

endmodule

// File: tb/tb_ask_demod.sv
// tb_ask_demod: directed bench for ask_demod with a queue-based window model
// and literal expectations on strobe timing and values.
module tb_ask_demod;
  import ask_pkg::*;

  localparam int SL = DEF_SYM_LEN;
  localparam int TH = DEF_THRESH;
  localparam int LS = DEF_LOSS_SYMS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ask_demod_if bus ();

  ask_demod #(
    .SYM_LEN   (SL),
    .THRESH    (TH),
    .LOSS_SYMS (LS),
    .CNT_W     (DEF_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  // Model: a window is the list of samples since the aligning edge; when it
  // holds SL samples it is summed and sliced.
  bit m_prev, m_lock, m_x, m_bv, m_stuck;
  int m_zrun;
  bit win_q[$];

  // Strobes seen on the DUT, with the output cycle they appeared in.
  int st_cyc[$];
  bit st_x[$];
  bit st_stuck[$];
  bit st_lock[$];
  int n_stuck;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_step(input bit yv, input bit rv);
    int n;
    m_bv    = 1'b0;
    m_stuck = 1'b0;
    if (rv) begin
      m_prev = 1'b0;
      m_lock = 1'b0;
      m_x    = 1'b0;
      m_zrun = 0;
      win_q.delete();
      return;
    end
    if (!m_lock) begin
      if (yv && !m_prev) begin
        m_lock = 1'b1;
        win_q.push_back(yv);
      end
    end else begin
      win_q.push_back(yv);
      if (win_q.size() == SL) begin
        n = 0;
        foreach (win_q[i]) n += int'(win_q[i]);
        win_q.delete();
        m_x     = (n >= TH);
        m_bv    = 1'b1;
        m_stuck = (n == SL);
        if (m_x) m_zrun = 0;
        else begin
          m_zrun++;
          if (LS > 0 && m_zrun == LS) begin
            m_lock = 1'b0;
            m_zrun = 0;
          end
        end
      end
    end
    m_prev = yv;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("x_out",     bus.x_out,     m_x);
      check("bit_valid", bus.bit_valid, m_bv);
      check("locked",    bus.locked,    m_lock);
      check("stuck_err", bus.stuck_err, m_stuck);
      if (bus.bit_valid === 1'b1) begin
        st_cyc.push_back(cyc + 1);
        st_x.push_back(bus.x_out);
        st_stuck.push_back(bus.stuck_err);
        st_lock.push_back(bus.locked);
      end
      if (bus.stuck_err === 1'b1) n_stuck++;
    end
  end

  task automatic step(input bit yv, input bit rv);
    bus.y = yv;
    rst   = rv;
    @(posedge clk);
    cyc++;
    model_step(yv, rv);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // One modulator symbol: carrier high 2 of every 4 clocks, gated by b.
  task automatic send_sym(input bit b);
    for (int p = 0; p < SL / CARRIER_DIV; p++) begin
      step(b, 1'b0);
      step(b, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
  endtask

  // Arbitrary window, sample i taken from pat[i].
  task automatic send_win(input logic [SL-1:0] pat);
    for (int i = 0; i < SL; i++) step(pat[i], 1'b0);
  endtask

  task automatic log_clear();
    st_cyc.delete();
    st_x.delete();
    st_stuck.delete();
    st_lock.delete();
    n_stuck = 0;
  endtask

  int edge_cyc;
  bit exp2[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    bus.y  = 1'b0;
    cmp_en = 1'b1;

    // 1: reset with y toggling, then idle low.
    for (int i = 0; i < 3; i++) step(bit'(i % 2), 1'b1);
    idle(5);
    check("t1_x_out",     bus.x_out,     0);
    check("t1_bit_valid", bus.bit_valid, 0);
    check("t1_locked",    bus.locked,    0);
    check("t1_stuck_err", bus.stuck_err, 0);

    // 2: modulator pattern 1,0,1,1 aligned at the first carrier rise.
    log_clear();
    edge_cyc = cyc + 1;
    step(1'b1, 1'b0);
    check("t2_locked_next", bus.locked, 1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int p = 1; p < SL / CARRIER_DIV; p++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    send_sym(1'b0);
    send_sym(1'b1);
    send_sym(1'b1);
    check("t2_n_strobes", st_cyc.size(), 4);
    for (int i = 0; i < 4 && i < st_cyc.size(); i++) begin
      check("t2_strobe_cyc", st_cyc[i] - edge_cyc, SL * (i + 1));
      check("t2_strobe_x",   st_x[i],              exp2[i]);
      check("t2_strobe_stk", st_stuck[i],          0);
    end
    check("t2_ideal_one", ideal_one_count(SL), 8);

    // 3: threshold boundary, 4 highs then 3 highs.
    log_clear();
    send_win(16'h0033);
    send_win(16'h0013);
    check("t3_n_strobes", st_cyc.size(), 2);
    if (st_cyc.size() == 2) begin
      check("t3_x_4high", st_x[0], 1);
      check("t3_x_3high", st_x[1], 0);
    end

    // 4: one 1-symbol then silence -> eight zero strobes and loss of lock.
    log_clear();
    send_sym(1'b1);
    idle(LS * SL + 20);
    check("t4_n_strobes", st_cyc.size(), 1 + LS);
    if (st_cyc.size() == 1 + LS) begin
      check("t4_first_x", st_x[0], 1);
      for (int i = 1; i <= LS; i++) check("t4_zero_x", st_x[i], 0);
      check("t4_lock_7th", st_lock[LS - 1], 1);
      check("t4_lock_8th", st_lock[LS],     0);
    end
    check("t4_unlocked", bus.locked, 0);
    log_clear();
    edge_cyc = cyc + 1;
    send_sym(1'b1);
    check("t4_relock_n",   st_cyc.size(), 1);
    if (st_cyc.size() == 1) begin
      check("t4_relock_cyc", st_cyc[0] - edge_cyc, SL);
      check("t4_relock_x",   st_x[0], 1);
    end

    // 5: full window of ones -> stuck strobe exactly once.
    log_clear();
    send_win('1);
    check("t5_n_strobes", st_cyc.size(), 1);
    if (st_cyc.size() == 1) begin
      check("t5_x",     st_x[0],     1);
      check("t5_stuck", st_stuck[0], 1);
    end
    send_sym(1'b1);
    check("t5_stuck_cycles", n_stuck, 1);
    check("t5_next_n", st_cyc.size(), 2);

    // 6: reset at phase 7, then a fresh alignment.
    log_clear();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    idle(20);
    check("t6_no_strobe", st_cyc.size(), 0);
    check("t6_locked",    bus.locked, 0);
    check("t6_x_out",     bus.x_out,  0);
    edge_cyc = cyc + 1;
    send_sym(1'b1);
    check("t6_relock_n", st_cyc.size(), 1);
    if (st_cyc.size() == 1) begin
      check("t6_relock_cyc", st_cyc[0] - edge_cyc, SL);
      check("t6_relock_x",   st_x[0], 1);
    end
    idle(3);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ask_demod.md
Name: ask_demod

Overview:
- Receive-side counterpart of the team's on-off-keying (ASK) modulator.
- That modulator gates a divide-by-4 carrier (high 2 of every 4 clocks) with the baseband bit.
- This block takes the 1-bit ASK waveform, which is clock-synchronous with clk, and aligns a symbol window to the first carrier burst.
- It counts high samples per window, slices each count against a threshold to recover the baseband bit, and drops lock after a run of empty symbols.

Parameters:
- SYM_LEN, 16, clocks per symbol; must be a multiple of 4 and at least 4.
- THRESH, 4, minimum high-sample count per window that decodes as 1; range 1..SYM_LEN.
- LOSS_SYMS, 8, consecutive decoded-0 symbols that force a return to hunt; 0 disables loss detection.
- CNT_W, 5, width of the phase and accumulator counters; must satisfy 2^CNT_W > SYM_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- y  in  1  ASK waveform, sampled every rising edge of clk.
- x_out  out  1  recovered bit; holds its value until the next decision.
- bit_valid  out  1  one-cycle strobe; x_out is new in this cycle.
- locked  out  1  high while the window is aligned (TRACK state).
- stuck_err  out  1  one-cycle strobe with bit_valid when all SYM_LEN samples were high (no carrier modulation).

Behaviour:
- Reset: on a clk edge with rst=1, the block enters HUNT. All of the following clear to 0: x_out, bit_valid, locked, stuck_err, phase, acc, zero_run, y_q. Reset takes priority over every other event, including mid-window.
- y_q is y registered once. A rising edge is the condition y=1 && y_q=0. Because y_q resets to 0, y high on the first cycle after reset counts as a rising edge.
- HUNT state:
  - locked=0.
  - On a rising edge, that cycle's sample is window sample 0: set state<=TRACK, phase<=1, acc<=1.
  - Other samples are ignored.
- TRACK state, every cycle:
  - acc<=acc+y.
  - phase<=phase+1.
- End of window, at phase==SYM_LEN-1:
  - Let n=acc+y.
  - x_out<=(n>=THRESH).
  - bit_valid<=1.
  - stuck_err<=(n==SYM_LEN).
  - phase<=0.
  - acc<=0.
- Decision latency: bit_valid is high in the cycle after the last sample of a window. The first strobe comes SYM_LEN cycles after the edge cycle; later strobes come every SYM_LEN cycles.
- Strobes: bit_valid and stuck_err are 0 in every other cycle.
- Loss detection, evaluated at each decision:
  - Decoded 1 clears zero_run.
  - Decoded 0 increments zero_run.
  - If LOSS_SYMS>0 and the incremented zero_run equals LOSS_SYMS: state<=HUNT and zero_run<=0. That bit's strobe is still emitted.
  - A rising edge in the very next cycle may relock immediately.
- locked: registered, equals (state==TRACK). It rises the cycle after the hunting edge and falls in the same cycle as the final loss strobe.
- Counter width: acc never exceeds SYM_LEN, and phase wraps at SYM_LEN-1, so no overflow is possible with a legal CNT_W.
- No re-alignment while in TRACK; edges inside a window are only counted.
- With the modulator's carrier, an ideal 1-symbol yields n=SYM_LEN/2 and a 0-symbol yields n=0.

Decomposition:
- Package ask_pkg holds:
  - state encodings HUNT=1'b0, TRACK=1'b1;
  - CARRIER_DIV=4;
  - default SYM_LEN/THRESH/LOSS_SYMS constants, shared with the modulator bench.
- Sub-module ask_win_acc holds the phase counter and high-sample accumulator.
  - Inputs: start, sample, enable.
  - Outputs: window_done, count.
- The parent keeps the FSM, slicer, zero_run counter and output registers.

Test Plan:
1. Reset: rst=1 for 3 cycles with y toggling -> x_out=0, bit_valid=0, locked=0, stuck_err=0 throughout and after release until the first edge.
2. Drive the modulator pattern for bits 1,0,1,1 (SYM_LEN=16, window aligned at the first carrier rise) -> locked=1 from the next cycle. bit_valid pulses at edge+16, +32, +48, +64 with x_out=1,0,1,1 and stuck_err=0.
3. Threshold boundary: a window containing exactly 4 high samples -> x_out=1; a window with 3 -> x_out=0.
4. Loss: one 1-symbol followed by y=0 -> eight strobes with x_out=0, and locked falls in the cycle of the 8th strobe. The next rising edge relocks, with the first strobe 16 cycles later.
5. y held high for a full window -> x_out=1, stuck_err=1 for exactly one cycle, coincident with bit_valid.
6. rst asserted at phase 7 of a window -> all outputs 0, no strobe for the partial window. The next rising edge starts a fresh window at phase 0.
